// File: rtl/fixed_point_divider_seq.sv
// Sequential signed fixed-point divider: restoring division on magnitudes,
// then a sign-fix / saturate stage, under a start/done handshake.
module fixed_point_divider_seq #(
  parameter int unsigned WI1 = 3,
  parameter int unsigned WF1 = 4,
  parameter int unsigned WI2 = 4,
  parameter int unsigned WF2 = 3,
  parameter int unsigned WIO = 4,
  parameter int unsigned WFO = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WI1+WF1-1:0]     in1,
  input  logic [WI2+WF2-1:0]     in2,
  output logic                   busy,
  output logic                   done,
  output logic                   overFlow,
  output logic                   divZero,
  output logic [WIO+WFO-1:0]     FixedPoint_Div_Out
);

  localparam int unsigned W1 = WI1 + WF1;
  localparam int unsigned W2 = WI2 + WF2;
  localparam int unsigned W  = WIO + WFO;
  localparam int unsigned S  = (WFO + WF2 >= WF1) ? (WFO + WF2 - WF1) : 0;
  localparam int unsigned N  = W1 + S;
  localparam int unsigned D  = W2 + 1;
  localparam int unsigned R  = D + 1;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned MW = ((N > W) ? N : W) + 1;

  localparam logic [MW-1:0] NEG_LIM = MW'(1) << (W - 1);
  localparam logic [MW-1:0] POS_LIM = NEG_LIM - MW'(1);
  localparam logic [W-1:0]  POS_SAT = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  NEG_SAT = {1'b1, {(W-1){1'b0}}};

  generate
    if (WFO + WF2 < WF1) begin : g_bad_format
      $error("fixed_point_divider_seq: WFO+WF2 must be >= WF1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    num;
  logic [N-1:0]    quo;
  logic [D-1:0]    rem;
  logic [D-1:0]    dmag;
  logic            neg_q;
  logic            in1_neg_q;
  logic            dz_q;

  // One bit wider than the operands so the most negative value negates exactly
  logic [W1:0]     in1_ext, in1_mag;
  logic [D-1:0]    in2_ext, in2_mag;

  always_comb begin
    in1_ext = {in1[W1-1], in1};
    in2_ext = {in2[W2-1], in2};
    in1_mag = in1[W1-1] ? ('0 - in1_ext) : in1_ext;
    in2_mag = in2[W2-1] ? ('0 - in2_ext) : in2_ext;
  end

  // Restoring division step: shift in next numerator bit, trial-subtract divisor
  logic [R-1:0]    rem_sh, trial;
  logic            q_bit;
  logic [D-1:0]    rem_nxt;

  always_comb begin
    rem_sh  = {rem, num[N-1]};
    q_bit   = (rem_sh >= R'(dmag));
    trial   = rem_sh - R'(dmag);
    rem_nxt = q_bit ? D'(trial) : D'(rem_sh);
  end

  // Sign fix and saturation; negative side reaches one further than positive
  logic [MW-1:0]   q_ext;
  logic [W-1:0]    res_c;
  logic            ovf_c;

  always_comb begin
    q_ext = MW'(quo);
    res_c = '0;
    ovf_c = 1'b0;
    if (dz_q) begin
      res_c = in1_neg_q ? NEG_SAT : POS_SAT;
      ovf_c = 1'b1;
    end else if (neg_q) begin
      if (q_ext > NEG_LIM) begin
        res_c = NEG_SAT;
        ovf_c = 1'b1;
      end else begin
        res_c = W'(MW'(0) - q_ext);
      end
    end else begin
      if (q_ext > POS_LIM) begin
        res_c = POS_SAT;
        ovf_c = 1'b1;
      end else begin
        res_c = W'(q_ext);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      cnt                <= '0;
      num                <= '0;
      quo                <= '0;
      rem                <= '0;
      dmag               <= '0;
      neg_q              <= 1'b0;
      in1_neg_q          <= 1'b0;
      dz_q               <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      overFlow           <= 1'b0;
      divZero            <= 1'b0;
      FixedPoint_Div_Out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dmag      <= in2_mag;
            num       <= N'(in1_mag) << S;
            neg_q     <= in1[W1-1] ^ in2[W2-1];
            in1_neg_q <= in1[W1-1];
            dz_q      <= (in2 == '0);
            rem       <= '0;
            quo       <= '0;
            cnt       <= CW'(N);
            busy      <= 1'b1;
            state     <= CALC;
          end
        end
        CALC: begin
          rem <= rem_nxt;
          quo <= {quo[N-2:0], q_bit};
          num <= num << 1;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          FixedPoint_Div_Out <= res_c;
          overFlow           <= ovf_c;
          divZero            <= dz_q;
          done               <= 1'b1;
          busy               <= 1'b0;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_divider_seq.sv
// Scoreboard bench for fixed_point_divider_seq at default Q-formats.
module tb_fixed_point_divider_seq;

  localparam int S   = 3;
  localparam int N   = 10;
  localparam int LAT = N + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] in1, in2;
  logic       busy, done, overFlow, divZero;
  logic [7:0] FixedPoint_Div_Out;

  fixed_point_divider_seq dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .overFlow(overFlow), .divZero(divZero),
    .FixedPoint_Div_Out(FixedPoint_Div_Out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] q;
    logic       ovf;
    logic       dz;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  logic prev_done = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [6:0] a, input logic [6:0] b);
    exp_t e;
    int ma, mb, q;
    logic neg;
    ma  = int'($signed(a));
    mb  = int'($signed(b));
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    neg = a[6] ^ b[6];
    e.dz = 1'b0;
    e.ovf = 1'b0;
    if (mb == 0) begin
      e.q = a[6] ? 8'h80 : 8'h7F;
      e.ovf = 1'b1;
      e.dz = 1'b1;
    end else begin
      q = (ma << S) / mb;
      if (neg) begin
        if (q > 128) begin e.q = 8'h80; e.ovf = 1'b1; end
        else e.q = 8'(-q);
      end else begin
        if (q > 127) begin e.q = 8'h7F; e.ovf = 1'b1; end
        else e.q = 8'(q);
      end
    end
    return e;
  endfunction

  // Result monitor: pops the scoreboard on every done pulse
  always @(posedge clk) begin
    #1;
    if (done) begin
      done_cnt++;
      check_eq("done_pulse", 32'(prev_done), 32'd0);
      check_eq("sb_nonempty", 32'(sb.size() == 0), 32'd0);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check_eq("result", 32'(FixedPoint_Div_Out), 32'(e.q));
        check_eq("overflow", 32'(overFlow), 32'(e.ovf));
        check_eq("divzero", 32'(divZero), 32'(e.dz));
      end
    end
    prev_done = done;
  end

  // One operation; intrude>0 pulses a second start at that cycle of the operation
  task automatic do_op(input logic [6:0] a, input logic [6:0] b, input exp_t e, input int intrude);
    int lat, bcnt;
    @(negedge clk);
    in1 = a;
    in2 = b;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    in1 = 7'($urandom);
    in2 = 7'($urandom);
    check_eq("hold_q", 32'(FixedPoint_Div_Out), 32'(last.q));
    check_eq("hold_ovf", 32'(overFlow), 32'(last.ovf));
    bcnt = int'(busy);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
      bcnt += int'(busy);
      if (intrude != 0 && lat == intrude) begin
        start = 1'b1;
        in1 = 7'h30;
        in2 = 7'h01;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_eq("latency", 32'(lat), 32'(LAT));
    check_eq("busy_cycles", 32'(bcnt), 32'(LAT));
    check_eq("busy_low_at_done", 32'(busy), 32'd0);
    last = e;
  endtask

  task automatic reset_abort(input logic [6:0] a, input logic [6:0] b);
    int snap;
    @(negedge clk);
    in1 = a;
    in2 = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    snap = done_cnt;
    rst = 1'b1;
    #1;
    check_eq("abort_q", 32'(FixedPoint_Div_Out), 32'd0);
    check_eq("abort_ovf", 32'(overFlow), 32'd0);
    check_eq("abort_dz", 32'(divZero), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check_eq("abort_no_done", 32'(done_cnt), 32'(snap));
    last = '0;
  endtask

  typedef struct packed {
    logic [6:0] a;
    logic [6:0] b;
    exp_t       e;
  } vec_t;

  vec_t plan[10];

  initial begin
    plan[0] = '{7'h28, 7'h08, '{8'h28, 1'b0, 1'b0}};
    plan[1] = '{7'h50, 7'h10, '{8'hE8, 1'b0, 1'b0}};
    plan[2] = '{7'h10, 7'h18, '{8'h05, 1'b0, 1'b0}};
    plan[3] = '{7'h70, 7'h18, '{8'hFB, 1'b0, 1'b0}};
    plan[4] = '{7'h30, 7'h01, '{8'h7F, 1'b1, 1'b0}};
    plan[5] = '{7'h40, 7'h08, '{8'hC0, 1'b0, 1'b0}};
    plan[6] = '{7'h40, 7'h7F, '{8'h7F, 1'b1, 1'b0}};
    plan[7] = '{7'h70, 7'h00, '{8'h80, 1'b1, 1'b1}};
    plan[8] = '{7'h00, 7'h00, '{8'h7F, 1'b1, 1'b1}};
    plan[9] = '{7'h28, 7'h08, '{8'h28, 1'b0, 1'b0}};

    rst = 1'b0;
    start = 1'b0;
    in1 = '0;
    in2 = '0;
    last = '0;
    #3 rst = 1'b1;
    #1;
    check_eq("rst_q", 32'(FixedPoint_Div_Out), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ovf", 32'(overFlow), 32'd0);
    check_eq("rst_dz", 32'(divZero), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) do_op(plan[i].a, plan[i].b, plan[i].e, 0);

    do_op(7'h50, 7'h10, '{8'hE8, 1'b0, 1'b0}, 4);

    reset_abort(7'h28, 7'h08);
    do_op(7'h10, 7'h18, '{8'h05, 1'b0, 1'b0}, 0);

    for (int i = 0; i < 24; i++) begin
      logic [6:0] a, b;
      a = 7'($urandom);
      b = (i % 8 == 7) ? 7'h00 : 7'($urandom);
      do_op(a, b, model(a, b), 0);
    end

    repeat (3) @(negedge clk);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fixed_point_divider_seq.md
Name: fixed_point_divider_seq

Overview:
Sequential signed fixed-point divider. It is the inverse-direction companion to the team's combinational fixed-point multiplier and uses the same Q-format parameterisation (WI/WF per operand and output) and the same overFlow flag semantics. It computes in1/in2 by one-bit-per-cycle restoring division on magnitudes, followed by a sign-fix and saturate stage, under a start/done handshake. It serves datapaths that need normalisation or reciprocal scaling of multiplier results.

Parameters:
WI1, 3, dividend integer length (incl. sign)
WF1, 4, dividend fraction length
WI2, 4, divisor integer length (incl. sign)
WF2, 3, divisor fraction length
WIO, 4, output integer length (incl. sign)
WFO, 4, output fraction length; constraint WFO+WF2 >= WF1 (elaboration error otherwise)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  request; sampled only in IDLE
in1  in  WI1+WF1  signed dividend
in2  in  WI2+WF2  signed divisor
busy  out  1  high from the accept edge until done
done  out  1  one-cycle pulse, result valid
overFlow  out  1  result saturated (range exceeded or divide by zero)
divZero  out  1  divisor was zero
FixedPoint_Div_Out  out  WIO+WFO  signed quotient, Q(WIO).(WFO)

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: FSM goes to IDLE. busy, done, overFlow, divZero and FixedPoint_Div_Out all go to 0. Reset aborts any operation in flight; no done is produced for it.
- Derived constants: S = WFO+WF2-WF1; N = WI1+WF1+S (quotient bits); W = WIO+WFO.
- Arithmetic: Q = trunc_toward_zero((|in1| << S) / |in2|). Sign = in1[msb] XOR in2[msb]. Output is Q if the sign is positive, otherwise -Q.
- Magnitudes are held in unsigned registers one bit wider than needed, so the most negative input value is handled exactly.
- Range: positive results are valid for Q <= 2^(W-1)-1; negative results are valid for Q <= 2^(W-1). Outside that range: saturate to 0x7F..F or 0x80..0 by sign, and set overFlow=1.
- Divide by zero (in2==0): divZero=1 and overFlow=1. Output is 0x80..0 if in1 < 0, else 0x7F..F (this includes in1==0). Latency is the same as a normal division.
- FSM states:
  - IDLE: busy=0. On start=1, capture the magnitudes, sign and zero flag, clear the remainder, load the counter with N, then go to CALC.
  - CALC: each cycle, shift the remainder and next numerator bit in, trial-subtract |in2|, shift the quotient bit in, and decrement the counter. After N cycles go to FIX.
  - FIX: apply sign, saturation and divZero handling, and register the outputs. Pulse done=1 and drop busy, then go to IDLE.
- Latency: with start accepted at edge k, done is high during the cycle after edge k+N+1. For the defaults, N=10, so latency is 11 cycles and the next start can be accepted on the edge where done is high.
- start while busy: ignored; there is no queueing.
- in1/in2 may change after the accept edge without affecting the result.
- FixedPoint_Div_Out, overFlow and divZero hold their values until the next FIX. They are not cleared by a new start.
- done is never asserted for two consecutive cycles.

Test Plan:
1. Defaults, in1=7'h28 (2.5), in2=7'h08 (1.0) -> done 11 cycles after start; FixedPoint_Div_Out=8'h28, overFlow=0, divZero=0; busy high for exactly 11 cycles.
2. in1=7'h50 (-3.0), in2=7'h10 (2.0) -> 8'hE8 (-1.5), overFlow=0.
3. in1=7'h10 (1.0), in2=7'h18 (3.0) -> 8'h05 (0.3125, truncated). in1=7'h70 (-1.0), same in2 -> 8'hFB (toward zero, not 8'hFA).
4. in1=7'h30 (3.0), in2=7'h01 (0.125) -> 8'h7F, overFlow=1. in1=7'h40 (-4.0), in2=7'h08 (1.0) -> 8'hC0, overFlow=0. in1=7'h40 (-4.0), in2=7'h7F (-0.125) -> 8'h7F, overFlow=1.
5. in2=0 with in1=7'h70 -> 8'h80, divZero=1, overFlow=1. Then in2=0 with in1=0 -> 8'h7F, divZero=1. Then a normal division -> divZero returns to 0.
6. Control: pulse start again at cycle 5 of an operation with different operands -> ignored, first result unchanged. Assert rst at cycle 6 of a new operation -> all outputs 0 asynchronously, no done. Start after reset release -> correct result after 11 cycles.
